// File: rtl/frame_painter.sv
// Frame painter: blanks the framebuffer once per frame, then turns the renderer's
// rx/ry pixel stream into registered framebuffer write strobes.
module frame_painter #(
  parameter int         WIDTH       = 640,
  parameter int         HEIGHT      = 480,
  parameter logic [2:0] BG_COLOR    = 3'b000,
  parameter logic [2:0] SNAKE_COLOR = 3'b010,
  parameter logic [2:0] FOOD_COLOR  = 3'b100
) (
  input  logic       draw_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] score,
  input  logic [9:0] rx,
  input  logic [8:0] ry,
  input  logic       write_done,
  output logic       cleared,
  output logic       fb_we,
  output logic [9:0] fb_x,
  output logic [8:0] fb_y,
  output logic [2:0] fb_color,
  output logic       busy,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HANDOFF,
    S_SETTLE,
    S_DRAW
  } state_t;

  localparam logic [9:0]  X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);
  localparam logic [10:0] X_LIM  = 11'(WIDTH);
  localparam logic [9:0]  Y_LIM  = 10'(HEIGHT);
  localparam logic [10:0] N_MAX  = 11'h7FF;

  state_t      r_state, w_state;
  logic        r_cleared, w_cleared;
  logic        r_fb_we, w_fb_we;
  logic [9:0]  r_fb_x, w_fb_x;
  logic [8:0]  r_fb_y, w_fb_y;
  logic [2:0]  r_fb_color, w_fb_color;
  logic        r_frame_done, w_frame_done;
  logic [10:0] r_n, w_n;

  logic [10:0] w_snake_limit;
  logic        w_in_range;

  // Body length in pixels; 15*100 still fits in 11 bits.
  assign w_snake_limit = {7'd0, score} * 11'd100;
  assign w_in_range    = ({1'b0, rx} < X_LIM) && ({1'b0, ry} < Y_LIM);

  // NOTE: every signal written here gets a default first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state      = r_state;
    w_cleared    = 1'b0;
    w_frame_done = 1'b0;
    w_fb_we      = 1'b0;
    w_fb_x       = r_fb_x;
    w_fb_y       = r_fb_y;
    w_fb_color   = r_fb_color;
    w_n          = r_n;

    unique case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_state    = S_CLEAR;
          w_fb_we    = 1'b1;
          w_fb_x     = '0;
          w_fb_y     = '0;
          w_fb_color = BG_COLOR;
        end
      end

      // fb_x/fb_y double as the sweep counters: the write shown this cycle is (cx, cy).
      S_CLEAR: begin
        if (r_fb_x == X_LAST && r_fb_y == Y_LAST) begin
          w_state   = S_HANDOFF;
          w_cleared = 1'b1;
        end else begin
          w_fb_we = 1'b1;
          if (r_fb_x == X_LAST) begin
            w_fb_x = '0;
            w_fb_y = r_fb_y + 9'd1;
          end else begin
            w_fb_x = r_fb_x + 10'd1;
          end
        end
      end

      S_HANDOFF: begin
        w_state = S_SETTLE;
        w_n     = '0;
      end

      // The renderer's first registered sample after cleared is stale; drop it.
      S_SETTLE: begin
        w_state = S_DRAW;
      end

      S_DRAW: begin
        if (write_done) begin
          w_state      = S_IDLE;
          w_frame_done = 1'b1;
        end else begin
          w_fb_x     = rx;
          w_fb_y     = ry;
          w_fb_we    = w_in_range;
          w_fb_color = (r_n < w_snake_limit) ? SNAKE_COLOR : FOOD_COLOR;
          w_n        = (r_n == N_MAX) ? r_n : r_n + 11'd1;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge draw_clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cleared    <= 1'b0;
      r_fb_we      <= 1'b0;
      r_fb_x       <= '0;
      r_fb_y       <= '0;
      r_fb_color   <= '0;
      r_frame_done <= 1'b0;
      r_n          <= '0;
    end else begin
      r_state      <= w_state;
      r_cleared    <= w_cleared;
      r_fb_we      <= w_fb_we;
      r_fb_x       <= w_fb_x;
      r_fb_y       <= w_fb_y;
      r_fb_color   <= w_fb_color;
      r_frame_done <= w_frame_done;
      r_n          <= w_n;
    end
  end

  assign cleared    = r_cleared;
  assign fb_we      = r_fb_we;
  assign fb_x       = r_fb_x;
  assign fb_y       = r_fb_y;
  assign fb_color   = r_fb_color;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_frame_painter.sv
// Self-checking bench for frame_painter on a 4x3 frame: a scoreboard holds every
// expected framebuffer write (address, colour, cycle) and the monitor pops on fb_we.
module tb_frame_painter;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [3:0] score;
  logic [9:0] rx;
  logic [8:0] ry;
  logic       write_done;
  logic       cleared;
  logic       fb_we;
  logic [9:0] fb_x;
  logic [8:0] fb_y;
  logic [2:0] fb_color;
  logic       busy;
  logic       frame_done;

  frame_painter #(.WIDTH(W), .HEIGHT(H)) dut (
    .draw_clk  (clk),
    .reset     (rst_n),
    .frame_tick(frame_tick),
    .score     (score),
    .rx        (rx),
    .ry        (ry),
    .write_done(write_done),
    .cleared   (cleared),
    .fb_we     (fb_we),
    .fb_x      (fb_x),
    .fb_y      (fb_y),
    .fb_color  (fb_color),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int color;
    int cyc;
  } wr_t;

  wr_t        sb[$];
  wr_t        mon_e;
  logic [9:0] px_x[$];
  logic [8:0] px_y[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_cleared = 0;
  int         n_done = 0;
  logic       cleared_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fb_we) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 32'(fb_x), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("wr_x", 32'(fb_x), mon_e.x);
        check("wr_y", 32'(fb_y), mon_e.y);
        check("wr_color", 32'(fb_color), mon_e.color);
        check("wr_cycle", cyc, mon_e.cyc);
      end
    end
    if (cleared && cleared_prev) check("cleared_width", 2, 1);
    if (cleared) n_cleared++;
    if (frame_done) n_done++;
    cleared_prev = cleared;
  end

  task automatic build_pixels(input int npix, input bit with_oob);
    px_x.delete();
    px_y.delete();
    for (int k = 0; k < npix; k++) begin
      px_x.push_back(10'(k % W));
      px_y.push_back(9'((k / W) % H));
    end
    if (with_oob) begin
      px_x[10]  = 10'd4;
      px_y[99]  = 9'd3;
      px_x[100] = 10'd1023;
      px_y[100] = 9'd511;
    end
  endtask

  // Caller is always positioned 1 time unit after a rising edge.
  task automatic run_frame(input logic [3:0] sc, input bit tick_clear, input bit tick_draw,
                           input bit tick_exit);
    int lim;
    bit got;
    lim   = int'(sc) * 100;
    score = sc;
    frame_tick = 1'b1;
    for (int k = 0; k < W * H; k++) sb.push_back('{k % W, k / W, 0, cyc + 1 + k});
    @(posedge clk); #1 frame_tick = 1'b0;

    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (cleared) got = 1'b1;
      else begin
        check("busy_clear", 32'(busy), 1);
        @(posedge clk); #1 frame_tick = tick_clear && (i == 3);
      end
    end
    frame_tick = 1'b0;
    check("cleared_seen", 32'(got), 1);
    if (!got) return;
    check("handoff_we", 32'(fb_we), 0);

    @(posedge clk); #1;                 // SETTLE: this sample must be discarded
    rx = 10'd0;
    ry = 9'd0;
    write_done = (px_x.size() == 0);
    @(posedge clk); #1;                 // now in DRAW

    for (int k = 0; k < px_x.size(); k++) begin
      rx = px_x[k];
      ry = px_y[k];
      frame_tick = tick_draw && (k == 3);
      if (px_x[k] < 10'(W) && px_y[k] < 9'(H))
        sb.push_back('{int'(px_x[k]), int'(px_y[k]), (k < lim) ? 2 : 4, cyc + 1});
      @(posedge clk); #1;
    end
    check("busy_draw", 32'(busy), 1);
    write_done = 1'b1;
    frame_tick = tick_exit;
    @(posedge clk); #1;
    write_done = 1'b0;
    frame_tick = 1'b0;
    @(negedge clk);
    check("frame_done_pulse", 32'(frame_done), 1);
    check("busy_after_done", 32'(busy), 0);
    check("we_after_done", 32'(fb_we), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("frame_done_width", 32'(frame_done), 0);
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1 check("idle_after_frame", 32'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    score = 4'd0;
    rx = '0;
    ry = '0;
    write_done = 1'b0;
    #12;
    check("rst_we", 32'(fb_we), 0);
    check("rst_cleared", 32'(cleared), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_addr", 32'({fb_x, fb_y, fb_color}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Sweep, then 100 snake + 2 food pixels.
    build_pixels(102, 1'b0);
    run_frame(4'd1, 1'b0, 1'b0, 1'b0);

    // Out-of-range pixels, plus ticks during clear, draw and the DRAW->IDLE cycle.
    build_pixels(102, 1'b1);
    run_frame(4'd1, 1'b1, 1'b1, 1'b1);

    // Reset asserted while (2,1) is being written.
    score = 4'd3;
    frame_tick = 1'b1;
    for (int k = 0; k < 7; k++) sb.push_back('{k % W, k / W, 0, cyc + 1 + k});
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_we", 32'(fb_we), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_cleared", 32'(cleared), 0);
    check("abort_sb", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("abort_no_cleared", n_cleared, 2);

    // score=0, write_done already high when DRAW is entered.
    build_pixels(0, 1'b0);
    run_frame(4'd0, 1'b0, 1'b0, 1'b0);

    // Largest score: 1500 snake pixels, then food.
    build_pixels(1502, 1'b0);
    run_frame(4'd15, 1'b0, 1'b0, 1'b0);

    check("sb_empty", sb.size(), 0);
    check("n_cleared", n_cleared, 4);
    check("n_frame_done", n_done, 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
